spi_seq: RTL and testbench
==========================

Name: spi_seq

Overview:
- Transaction sequencer placed directly upstream of the byte-level SPI master (spi).
- Accepts a burst command of N bytes, pulls TX bytes from a valid/ready stream, and issues one master transfer per byte via spi_enable/data_in.
- Captures each received byte from the master's valid_out/data_out and forwards it on an RX valid/ready stream. Signals done or err at burst end.

Parameters:
- DATA_BITS, 8: byte width; must match the master's DATA_BITS.
- LEN_BITS, 8: width of the burst length field.
- TIMEOUT_CYCLES, 1024: clk cycles allowed per byte before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous reset, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_len  in  LEN_BITS  number of bytes in the burst
- cmd_rx_en  in  1  1: forward RX bytes; 0: discard them (write-only burst)
- tx_valid  in  1  TX byte offered
- tx_ready  out  1  TX byte accepted this cycle
- tx_data  in  DATA_BITS  TX byte
- rx_valid  out  1  RX byte available
- rx_ready  in  1  consumer takes RX byte
- rx_data  out  DATA_BITS  RX byte
- rx_last  out  1  RX byte is the final byte of the burst
- spi_enable  out  1  to master spi_enable
- spi_data_in  out  DATA_BITS  to master data_in
- spi_ready  in  1  from master ready_out
- spi_valid  in  1  from master valid_out
- spi_data_out  in  DATA_BITS  from master data_out
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst end
- err  out  1  one-cycle pulse on timeout abort (coincides with done)

Behaviour:
- Reset: n_rst is asynchronous and active-low; clock is clk.
- All outputs are 0 during reset: cmd_ready, tx_ready, rx_valid, rx_data, rx_last, spi_enable, spi_data_in, busy, done, err. The FSM enters IDLE.
- cmd_ready rises in the first cycle in IDLE after reset release.
- FSM states: IDLE, FETCH, ARM, START, XFER.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_len into rem and cmd_rx_en into rx_en.
  - If cmd_len==0: pulse done next cycle and stay in IDLE. Otherwise go to FETCH with busy=1.
- FETCH:
  - tx_ready=1 (combinational, FETCH only).
  - On tx_valid, register tx_data into spi_data_in and go to ARM.
- ARM:
  - Wait until spi_ready==1 and rx_valid==0 (RX slot empty).
  - Then assert spi_enable for exactly one cycle and go to START.
- START:
  - spi_enable=0. Wait for spi_ready==0 (master left idle), then go to XFER.
- XFER:
  - Wait for a rising edge of spi_valid (spi_valid=1 while the registered previous value is 0).
  - On the edge, capture spi_data_out. If rx_en, load rx_data, set rx_valid=1, and set rx_last=(rem==1).
  - Decrement rem.
  - If rem becomes 0: pulse done, clear busy, go to IDLE. Otherwise go to FETCH.
- RX slot:
  - rx_valid holds, with rx_data and rx_last stable, until rx_valid&&rx_ready; it clears the following cycle.
  - A full slot stalls ARM. No byte is ever dropped while rx_en=1.
- Simultaneous events:
  - rx handshake in the same cycle ARM evaluates: ARM still sees rx_valid=1 and fires one cycle later.
  - cmd_valid while busy: ignored (cmd_ready=0).
- spi_data_in holds its value until the next FETCH load.
- rem is LEN_BITS wide; the maximum burst is 2^LEN_BITS-1 bytes; no wrap occurs.
- Reset mid-burst returns everything to reset values immediately. Partially sent TX bytes are not replayed.

Optional Feature:
- Macro: SPI_SEQ_TIMEOUT_EN.
- When defined:
  - A per-byte counter clears on entry to START and increments in START and XFER.
  - When it reaches TIMEOUT_CYCLES-1 without an spi_valid edge, pulse err and done together, clear busy, and return to IDLE.
  - Remaining TX bytes are not consumed; the RX slot is left untouched.
- When undefined: no counter exists, err is tied to 0, and the FSM waits indefinitely.

Decomposition:
- Shared package spi_pkg:
  - state enum spi_seq_state_t.
  - localparam defaults for DATA_BITS and LEN_BITS.
- One sub-module: spi_seq_rx_slot, the one-entry RX holding register with its valid/ready logic.

Test Plan:
- cmd_len=3, rx_en=1, TX 0xA5,0x3C,0xF0, master model with loopback MISO -> three spi_enable pulses, RX 0xA5,0x3C,0xF0, rx_last only on 0xF0, single done pulse, busy low afterwards.
- cmd_len=0 -> done pulses one cycle after acceptance; no spi_enable and no tx_ready.
- cmd_len=2, rx_en=0 -> two transfers, rx_valid never asserted, done once.
- cmd_len=2, rx_ready held low for 50 cycles after the first byte -> second spi_enable delayed until the first RX byte is consumed; no data loss.
- SPI_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=64, master never raises spi_valid -> err and done together 64 cycles after START; cmd_ready returns high.
- n_rst asserted during XFER of byte 2 of 4 -> all outputs 0 immediately; the next command runs cleanly from byte 1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI transaction sequencer.
package spi_pkg;
  localparam int SPI_DATA_BITS = 8;
  localparam int SPI_LEN_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ARM,
    ST_START,
    ST_XFER
  } spi_seq_state_t;
endpackage

// File: rtl/spi_seq_rx_slot.sv
// One-entry RX holding register; data and last stay stable while valid is pending.
module spi_seq_rx_slot
  import spi_pkg::*;
#(
  parameter int DATA_BITS = SPI_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 load_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 last_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 last_o
);
  logic                 valid_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 last_q;

  // The sequencer only loads into an empty slot, so a load never overwrites.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
endmodule

// File: rtl/spi_seq.sv
// Burst sequencer in front of the byte-level SPI master: one master transfer per byte.
// Optional per-byte timeout abort enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_seq
  import spi_pkg::*;
#(
  parameter int DATA_BITS      = SPI_DATA_BITS,
  parameter int LEN_BITS       = SPI_LEN_BITS,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_BITS-1:0]  cmd_len,
  input  logic                 cmd_rx_en,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_last,
  output logic                 spi_enable,
  output logic [DATA_BITS-1:0] spi_data_in,
  input  logic                 spi_ready,
  input  logic                 spi_valid,
  input  logic [DATA_BITS-1:0] spi_data_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  spi_seq_state_t       state_q, state_d;
  logic [LEN_BITS-1:0]  rem_q, rem_d;
  logic                 rx_en_q, rx_en_d;
  logic [DATA_BITS-1:0] dat_q, dat_d;
  logic                 spi_valid_q;
  logic                 cmd_ready_q, busy_q, done_q, done_d;
  logic                 rx_load, spi_edge;

  assign spi_edge = spi_valid && !spi_valid_q;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    rx_en_d    = rx_en_q;
    dat_d      = dat_q;
    done_d     = 1'b0;
    rx_load    = 1'b0;
    tx_ready   = 1'b0;
    spi_enable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rem_d   = cmd_len;
          rx_en_d = cmd_rx_en;
          if (cmd_len == '0) done_d = 1'b1;
          else               state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          dat_d   = tx_data;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        // A full RX slot holds off the next transfer so no byte is lost.
        if (spi_ready && !rx_valid) begin
          spi_enable = 1'b1;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (!spi_ready) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (spi_edge) begin
          rx_load = rx_en_q;
          rem_d   = rem_q - LEN_BITS'(1);
          if (rem_q == LEN_BITS'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef SPI_SEQ_TIMEOUT_EN
    err_d    = 1'b0;
    to_cnt_d = to_cnt_q;
    if (state_q == ST_ARM) to_cnt_d = '0;
    if (state_q == ST_START || state_q == ST_XFER) begin
      to_cnt_d = to_cnt_q + CNT_W'(1);
      if (!spi_edge && to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        err_d   = 1'b1;
        rx_load = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      rx_en_q     <= 1'b0;
      dat_q       <= '0;
      spi_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      rx_en_q     <= rx_en_d;
      dat_q       <= dat_d;
      spi_valid_q <= spi_valid;
      cmd_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= done_d;
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  spi_seq_rx_slot #(.DATA_BITS(DATA_BITS)) u_rx_slot (
    .clk     (clk),
    .n_rst   (n_rst),
    .load_i  (rx_load),
    .data_i  (spi_data_out),
    .last_i  (rem_q == LEN_BITS'(1)),
    .ready_i (rx_ready),
    .valid_o (rx_valid),
    .data_o  (rx_data),
    .last_o  (rx_last)
  );

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign spi_data_in = dat_q;
endmodule

// File: tb/tb_spi_seq.sv
// Scoreboard bench for spi_seq with a loopback byte-master model.
module tb_spi_seq;
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       cmd_valid = 1'b0, cmd_rx_en = 1'b0;
  logic [7:0] cmd_len = '0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       rx_ready = 1'b1;
  logic       cmd_ready, tx_ready, rx_valid, rx_last, spi_enable, busy, done, err;
  logic [7:0] rx_data, spi_data_in;
  logic       m_ready, m_valid, mute = 1'b0;
  logic [7:0] m_dout, m_sh;
  logic [3:0] m_cnt;

  always #5 clk = ~clk;

  spi_seq #(.DATA_BITS(8), .LEN_BITS(8), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_rx_en(cmd_rx_en),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_last(rx_last),
    .spi_enable(spi_enable), .spi_data_in(spi_data_in),
    .spi_ready(m_ready), .spi_valid(m_valid), .spi_data_out(m_dout),
    .busy(busy), .done(done), .err(err)
  );

  // Master model: drops ready after enable, returns the sent byte after a few cycles.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_ready <= 1'b1; m_valid <= 1'b0; m_dout <= '0; m_sh <= '0; m_cnt <= '0;
    end else begin
      m_valid <= 1'b0;
      if (m_ready) begin
        if (spi_enable) begin
          m_ready <= 1'b0; m_sh <= spi_data_in; m_cnt <= 4'd4;
        end
      end else if (m_cnt != 0) m_cnt <= m_cnt - 4'd1;
      else if (!mute) begin
        m_valid <= 1'b1; m_dout <= m_sh; m_ready <= 1'b1;
      end
    end
  end

  int tests = 0, fails = 0;
  int en_cnt = 0, done_cnt = 0, err_cnt = 0, txr_cnt = 0, rxv_cnt = 0;
  typedef struct packed { logic [7:0] d; logic l; } rx_t;
  rx_t        expq[$];
  logic [7:0] txq[$];
  logic [7:0] en_data[$];
  wire [23:0] outs = {cmd_ready, tx_ready, rx_valid, rx_data, rx_last, spi_enable,
                      spi_data_in, busy, done, err};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every RX handshake pops and compares one expected byte.
  always @(negedge clk) begin
    if (n_rst) begin
      if (rx_valid && rx_ready) begin
        if (expq.size() == 0) begin
          tests++; fails++;
          $display("FAIL rx_unexpected: got %0h expected none", rx_data);
        end else begin
          rx_t e;
          e = expq.pop_front();
          chk("rx_data", rx_data, e.d);
          chk("rx_last", rx_last, e.l);
        end
      end
      if (spi_enable) begin en_cnt++; en_data.push_back(spi_data_in); end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (tx_ready) txr_cnt++;
      if (rx_valid) rxv_cnt++;
    end
  end

  // TX stream driver fed from txq.
  initial begin
    logic take;
    forever begin
      @(negedge clk);
      take = tx_valid && tx_ready;
      @(posedge clk); #1;
      if (take && txq.size() != 0) void'(txq.pop_front());
      tx_valid = (txq.size() != 0);
      tx_data  = (txq.size() != 0) ? txq[0] : 8'h00;
    end
  end

  task automatic nstep();
    @(negedge clk); #1;
  endtask

  task automatic send_cmd(input logic [7:0] len, input logic rxen);
    int n = 0;
    @(posedge clk); #1;
    while (!cmd_ready && n < 500) begin @(posedge clk); #1; n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_len = len; cmd_rx_en = rxen; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    nstep();
    while (!done && n < 3000) begin nstep(); n++; end
    chk("done_seen", done, 1);
  endtask

  initial begin
    int b_en, b_done, b_txr, b_rxv, c;
    // Reset state
    repeat (3) nstep();
    chk("reset_outputs", outs, 0);
    @(posedge clk); #1; n_rst = 1'b1;
    @(posedge clk); #1;
    chk("cmd_ready_after_reset", cmd_ready, 1);
    chk("busy_after_reset", busy, 0);

    // Three-byte read/write burst
    b_en = en_cnt; b_done = done_cnt; en_data.delete();
    txq.push_back(8'hA5); txq.push_back(8'h3C); txq.push_back(8'hF0);
    expq.push_back('{8'hA5, 1'b0}); expq.push_back('{8'h3C, 1'b0}); expq.push_back('{8'hF0, 1'b1});
    send_cmd(8'd3, 1'b1);
    chk("busy_in_burst", busy, 1);
    wait_done();
    chk("t1_no_err", err, 0);
    repeat (3) nstep();
    chk("t1_enables", en_cnt - b_en, 3);
    chk("t1_en_data0", en_data[0], 8'hA5);
    chk("t1_en_data1", en_data[1], 8'h3C);
    chk("t1_en_data2", en_data[2], 8'hF0);
    chk("t1_done_once", done_cnt - b_done, 1);
    chk("t1_busy_low", busy, 0);
    chk("t1_rx_all_seen", expq.size(), 0);

    // Zero-length command
    b_en = en_cnt; b_done = done_cnt; b_txr = txr_cnt;
    send_cmd(8'd0, 1'b1);
    nstep();
    chk("t2_done_next_cycle", done, 1);
    chk("t2_busy", busy, 0);
    repeat (3) nstep();
    chk("t2_no_enable", en_cnt - b_en, 0);
    chk("t2_no_tx_ready", txr_cnt - b_txr, 0);
    chk("t2_done_once", done_cnt - b_done, 1);

    // Write-only burst
    b_en = en_cnt; b_done = done_cnt; b_rxv = rxv_cnt;
    txq.push_back(8'h11); txq.push_back(8'h22);
    send_cmd(8'd2, 1'b0);
    wait_done();
    repeat (3) nstep();
    chk("t3_enables", en_cnt - b_en, 2);
    chk("t3_no_rx_valid", rxv_cnt - b_rxv, 0);
    chk("t3_done_once", done_cnt - b_done, 1);

    // RX back-pressure stalls the next transfer
    @(posedge clk); #1; rx_ready = 1'b0;
    b_en = en_cnt;
    txq.push_back(8'h5A); txq.push_back(8'hC3);
    expq.push_back('{8'h5A, 1'b0}); expq.push_back('{8'hC3, 1'b1});
    send_cmd(8'd2, 1'b1);
    c = 0;
    while (!rx_valid && c < 200) begin nstep(); c++; end
    chk("t4_rx_valid_seen", rx_valid, 1);
    repeat (50) nstep();
    chk("t4_stalled_enables", en_cnt - b_en, 1);
    chk("t4_rx_held", rx_data, 8'h5A);
    @(posedge clk); #1; rx_ready = 1'b1;
    wait_done();
    repeat (3) nstep();
    chk("t4_enables", en_cnt - b_en, 2);
    chk("t4_rx_all_seen", expq.size(), 0);

    // Reset during byte 2 of 4, then a clean burst
    b_en = en_cnt;
    txq.push_back(8'h01); txq.push_back(8'h02); txq.push_back(8'h03); txq.push_back(8'h04);
    expq.push_back('{8'h01, 1'b0});
    send_cmd(8'd4, 1'b1);
    c = 0;
    while (en_cnt - b_en < 2 && c < 500) begin nstep(); c++; end
    chk("t5_second_enable", en_cnt - b_en, 2);
    repeat (2) nstep();
    n_rst = 1'b0; #1;
    chk("t5_reset_outputs", outs, 0);
    chk("t5_byte1_received", expq.size(), 0);
    txq.delete();
    repeat (2) @(posedge clk);
    #1; n_rst = 1'b1;
    b_en = en_cnt; b_done = done_cnt; en_data.delete();
    txq.push_back(8'h77); txq.push_back(8'h88);
    expq.push_back('{8'h77, 1'b0}); expq.push_back('{8'h88, 1'b1});
    send_cmd(8'd2, 1'b1);
    wait_done();
    repeat (3) nstep();
    chk("t5_enables", en_cnt - b_en, 2);
    chk("t5_first_byte", en_data[0], 8'h77);
    chk("t5_done_once", done_cnt - b_done, 1);
    chk("t5_rx_all_seen", expq.size(), 0);
    chk("no_err_so_far", err_cnt, 0);

`ifdef SPI_SEQ_TIMEOUT_EN
    // Master never answers: abort 64 cycles after START
    mute = 1'b1;
    txq.push_back(8'h99);
    send_cmd(8'd1, 1'b1);
    c = 0;
    while (!spi_enable && c < 200) begin nstep(); c++; end
    chk("t6_enable_seen", spi_enable, 1);
    c = 0;
    nstep(); c++;
    while (!done && c < 300) begin nstep(); c++; end
    chk("t6_timeout_cycles", c, 65);
    chk("t6_err_with_done", err, 1);
    nstep();
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_busy", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
